// File: rtl/mul_seq_nb_if.sv
// Handshake bundle for the sequential multiplier: request side (start/x/y)
// and completion side (busy/done/z).
interface mul_seq_nb_if #(
    parameter int unsigned N = 8
);
    logic             start;
    logic [N-1:0]     x;
    logic [N-1:0]     y;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   z;

    modport master (
        output start,
        output x,
        output y,
        input  busy,
        input  done,
        input  z
    );

    modport slave (
        input  start,
        input  x,
        input  y,
        output busy,
        output done,
        output z
    );
endinterface

// File: rtl/mul_seq_nb.sv
// Sequential shift-add multiplier: N CALC cycles, unsigned or two's-complement.
// Signed operands are reduced to magnitudes up front and the sign is reapplied at FIN.
module mul_seq_nb #(
    parameter int unsigned N      = 8,
    parameter bit          SIGNED = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    mul_seq_nb_if.slave   bus
);
    localparam int unsigned W    = 2 * N;
    localparam int unsigned CntW = $clog2(N + 1);

    localparam logic [N-1:0]    NOne    = 1;
    localparam logic [W-1:0]    WOne    = 1;
    localparam logic [CntW-1:0] CntOne  = 1;
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFin
    } state_e;

    state_e          state;
    logic [W-1:0]    mcand;
    logic [N-1:0]    mplier;
    logic [W-1:0]    acc;
    logic [CntW-1:0] cnt;
    logic            neg;
    logic            busy_r;
    logic            done_r;
    logic [W-1:0]    z_r;

    logic [N-1:0]    x_mag;
    logic [N-1:0]    y_mag;
    logic            neg_in;

    // |-2^(N-1)| wraps back to 2^(N-1), which is the right unsigned magnitude.
    always_comb begin
        x_mag  = bus.x;
        y_mag  = bus.y;
        neg_in = 1'b0;
        if (SIGNED) begin
            if (bus.x[N-1]) begin
                x_mag = ~bus.x + NOne;
            end
            if (bus.y[N-1]) begin
                y_mag = ~bus.y + NOne;
            end
            neg_in = bus.x[N-1] ^ bus.y[N-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= StIdle;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            z_r    <= '0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (bus.start) begin
                        mcand  <= {{N{1'b0}}, x_mag};
                        mplier <= y_mag;
                        acc    <= '0;
                        cnt    <= '0;
                        neg    <= neg_in;
                        busy_r <= 1'b1;
                        state  <= StCalc;
                    end
                end
                StCalc: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CntOne;
                    if (cnt == CntLast) begin
                        state <= StFin;
                    end
                end
                StFin: begin
                    // Negating a zero accumulator yields zero, so no negative zero.
                    z_r    <= neg ? (~acc + WOne) : acc;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.z    = z_r;
endmodule
